mc_datapath: RTL and testbench

Multicycle CPU datapath: the storage/execution end of the control-signal interface driven by the multicycle controller FSM. It holds the PC, the register file, all architectural and inter-cycle registers (IR, MDR, A, B, ALUOut) and the ALU. It drives a unified instruction/data memory port and returns the opcode and branch status to the controller. Each cycle it applies whatever control word is presented; it has no state machine of its own.

---
 rtl/mc_datapath_if.sv | 46 ++++
 rtl/mc_datapath.sv | 132 +++++++++++++
 tb/tb_mc_datapath.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_datapath_if.sv
// Control-word and memory bus between the multicycle controller, the
// unified memory and the datapath. The master side is the controller plus
// memory environment; the slave side is the datapath itself.
interface mc_datapath_if;
    // control word presented each cycle
    logic [2:0]  alu_op;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic        nbit_branch_select;
    logic [1:0]  pc_source;
    logic        pc_write;
    logic        pc_write_cond;
    logic        beq_bne;
    logic        ir_write;
    logic        i_or_d;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;

    // unified instruction/data memory port
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_rdata;

    // status back to the controller
    logic [5:0]  op;
    logic        zero;
    logic [31:0] pc;

    modport master (
        output alu_op, alu_src_a, alu_src_b, nbit_branch_select, pc_source,
               pc_write, pc_write_cond, beq_bne, ir_write, i_or_d,
               mem_read, mem_write, reg_write, mem_to_reg, mem_rdata,
        input  mem_addr, mem_wdata, mem_re, mem_we, op, zero, pc
    );

    modport slave (
        input  alu_op, alu_src_a, alu_src_b, nbit_branch_select, pc_source,
               pc_write, pc_write_cond, beq_bne, ir_write, i_or_d,
               mem_read, mem_write, reg_write, mem_to_reg, mem_rdata,
        output mem_addr, mem_wdata, mem_re, mem_we, op, zero, pc
    );
endinterface

// File: rtl/mc_datapath.sv
// Multicycle CPU datapath: PC, register file, IR/MDR/A/B/ALUOut and the ALU.
// It has no sequencing of its own; every cycle it applies the control word
// it is given and reports opcode and ALU zero back to the controller.
module mc_datapath #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    mc_datapath_if.slave bus_io
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] ir_q;
    logic [31:0] mdr_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] aluOut_q;
    logic [31:0] regFile_q [32];

    logic [4:0]  rsField;
    logic [4:0]  rtField;
    logic [4:0]  rdField;
    logic [4:0]  destReg;
    logic [31:0] immZext;
    logic [31:0] immSext;
    logic [31:0] aluInA;
    logic [31:0] aluInB;
    logic [31:0] aluResult;
    logic [31:0] writeData;
    logic        zeroFlag;
    logic        pcLoad;

    assign rsField = ir_q[25:21];
    assign rtField = ir_q[20:16];
    assign rdField = ir_q[15:11];

    // R-type opcodes (op[5:4] == 01) write rd; everything else writes rt
    assign destReg = (ir_q[31:30] == 2'b01) ? rdField : rtField;

    assign immZext = {16'h0000, ir_q[15:0]};
    assign immSext = bus_io.nbit_branch_select ? {{16{ir_q[15]}}, ir_q[15:0]}
                                               : {{21{ir_q[10]}}, ir_q[10:0]};

    assign writeData = bus_io.mem_to_reg ? mdr_q : aluOut_q;

    // ALU operand selection
    always_comb begin
        aluInA = bus_io.alu_src_a ? a_q : pc_q;
        aluInB = b_q;
        case (bus_io.alu_src_b)
            2'b00:   aluInB = b_q;
            2'b01:   aluInB = 32'd1;
            2'b10:   aluInB = immZext;
            default: aluInB = immSext;
        endcase
    end

    // ALU: wrap-around arithmetic, signed set-less-than, no overflow flag
    always_comb begin
        aluResult = '0;
        case (bus_io.alu_op)
            3'b000:  aluResult = aluInA & aluInB;
            3'b001:  aluResult = aluInA | aluInB;
            3'b010:  aluResult = aluInA + aluInB;
            3'b011:  aluResult = aluInA - aluInB;
            3'b100:  aluResult = {31'd0, ($signed(aluInA) < $signed(aluInB))};
            3'b101:  aluResult = aluInA ^ aluInB;
            3'b110:  aluResult = ~(aluInA | aluInB);
            default: aluResult = aluInB;
        endcase
    end

    assign zeroFlag = (aluResult == 32'd0);

    // A branch loads the PC when the zero flag disagrees with beq_bne
    assign pcLoad = bus_io.pc_write | (bus_io.pc_write_cond & (zeroFlag ^ bus_io.beq_bne));

    // next-PC source selection
    always_comb begin
        pc_d = pc_q;
        case (bus_io.pc_source)
            2'b00:   pc_d = aluResult;
            2'b01:   pc_d = aluOut_q;
            2'b10:   pc_d = {pc_q[31:26], ir_q[25:0]};
            default: pc_d = pc_q;
        endcase
    end

    // PC and inter-cycle registers; reset wins over every enable
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            mdr_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluOut_q <= '0;
        end else begin
            if (pcLoad) begin
                pc_q <= pc_d;
            end
            if (bus_io.ir_write) begin
                ir_q <= bus_io.mem_rdata;
            end
            mdr_q    <= bus_io.mem_rdata;
            a_q      <= regFile_q[rsField];
            b_q      <= regFile_q[rtField];
            aluOut_q <= aluResult;
        end
    end

    // register file write port; r0 is never written so it always reads 0
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regFile_q[i] <= '0;
            end
        end else if (bus_io.reg_write && (destReg != 5'd0)) begin
            regFile_q[destReg] <= writeData;
        end
    end

    assign bus_io.mem_addr  = bus_io.i_or_d ? aluOut_q : pc_q;
    assign bus_io.mem_wdata = b_q;
    assign bus_io.mem_re    = bus_io.mem_read;
    assign bus_io.mem_we    = bus_io.mem_write;
    assign bus_io.op        = ir_q[31:26];
    assign bus_io.zero      = zeroFlag;
    assign bus_io.pc        = pc_q;

endmodule

// File: tb/tb_mc_datapath.sv
// Self-checking bench for mc_datapath. A small word memory answers the
// memory port; register contents are observed through B on mem_wdata and
// ALUOut through mem_addr with i_or_d = 1.
module tb_mc_datapath;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mc_datapath_if bus ();

    mc_datapath #(.RESET_PC(32'h0000_0000)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    logic [31:0] memArr [64];
    assign bus.mem_rdata = memArr[bus.mem_addr[5:0]];

    int checks = 0;
    int errors = 0;

    string       nameQ [$];
    logic [31:0] valQ  [$];

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [4:0]  rd;
        logic [31:0] res;
    } aluVec_t;

    aluVec_t vecTable [12];

    // compare one observed value against its expectation
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic pushExp(input string name, input logic [31:0] value);
        nameQ.push_back(name);
        valQ.push_back(value);
    endtask

    task automatic popCheck(input logic [31:0] actual);
        string       n;
        logic [31:0] v;
        if (valQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: output %h with no expectation queued", actual);
        end else begin
            n = nameQ.pop_front();
            v = valQ.pop_front();
            checkOutput(n, actual, v);
        end
    endtask

    task automatic setIdle();
        bus.alu_op             = 3'b000;
        bus.alu_src_a          = 1'b0;
        bus.alu_src_b          = 2'b00;
        bus.nbit_branch_select = 1'b1;
        bus.pc_source          = 2'b11;
        bus.pc_write           = 1'b0;
        bus.pc_write_cond      = 1'b0;
        bus.beq_bne            = 1'b0;
        bus.ir_write           = 1'b0;
        bus.i_or_d             = 1'b0;
        bus.mem_read           = 1'b0;
        bus.mem_write          = 1'b0;
        bus.reg_write          = 1'b0;
        bus.mem_to_reg         = 1'b0;
    endtask

    // one clock; the memory model performs any store the DUT requests
    task automatic tick();
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        #1;
        we   = bus.mem_we;
        addr = bus.mem_addr;
        data = bus.mem_wdata;
        @(posedge clk);
        #1;
        if (we) memArr[addr[5:0]] = data;
    endtask

    // load IR from the word placed at the current PC, PC unchanged
    task automatic loadIr(input logic [31:0] word);
        setIdle();
        memArr[bus.pc[5:0]] = word;
        bus.ir_write = 1'b1;
        tick();
        setIdle();
    endtask

    // write a register through the MDR writeback path
    task automatic writeReg(input logic [4:0] r, input logic [31:0] value);
        loadIr({6'h23, 5'd0, r, 16'h0000});
        memArr[bus.pc[5:0]] = value;
        tick();
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        tick();
        setIdle();
    endtask

    // read a register back through B onto mem_wdata
    task automatic readReg(input string name, input logic [4:0] r, input logic [31:0] expected);
        loadIr({6'h23, 5'd0, r, 16'h0000});
        pushExp(name, expected);
        tick();
        popCheck(bus.mem_wdata);
    endtask

    // run one table vector: rs=r1, rt=r2, execute, write back to rd, read rd
    task automatic applyStimulus(input aluVec_t v);
        writeReg(5'd1, v.a);
        writeReg(5'd2, v.b);
        loadIr({6'h10, 5'd1, 5'd2, v.rd, 11'd0});
        tick();
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b00;
        bus.alu_op    = v.op;
        bus.i_or_d    = 1'b1;
        #1;
        checkOutput("alu zero", {31'd0, bus.zero}, {31'd0, (v.res == 32'd0)});
        pushExp("aluout", v.res);
        tick();
        popCheck(bus.mem_addr);
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b0;
        tick();
        setIdle();
        readReg("rf writeback", v.rd, (v.rd == 5'd0) ? 32'd0 : v.res);
    endtask

    // jump to PC 4, fetch a branch comparing r1 and r2, decode, branch
    task automatic doBranch(input logic [15:0] imm, input logic nbit, input logic beqBne,
                            input logic [31:0] expTarget, input logic [31:0] expPc);
        loadIr({6'h02, 26'd4});
        bus.pc_write  = 1'b1;
        bus.pc_source = 2'b10;
        pushExp("jump to 4", 32'd4);
        tick();
        setIdle();
        popCheck(bus.pc);
        memArr[4] = {6'h04, 5'd1, 5'd2, imm};
        bus.alu_src_a = 1'b0;
        bus.alu_src_b = 2'b01;
        bus.alu_op    = 3'b010;
        bus.pc_source = 2'b00;
        bus.pc_write  = 1'b1;
        bus.ir_write  = 1'b1;
        tick();
        setIdle();
        bus.alu_src_a          = 1'b0;
        bus.alu_src_b          = 2'b11;
        bus.nbit_branch_select = nbit;
        bus.alu_op             = 3'b010;
        tick();
        setIdle();
        bus.alu_src_a     = 1'b1;
        bus.alu_src_b     = 2'b00;
        bus.alu_op        = 3'b011;
        bus.pc_source     = 2'b01;
        bus.pc_write_cond = 1'b1;
        bus.beq_bne       = beqBne;
        bus.i_or_d        = 1'b1;
        #1;
        checkOutput("branch target", bus.mem_addr, expTarget);
        checkOutput("branch zero", {31'd0, bus.zero}, 32'd1);
        pushExp("branch pc", expPc);
        tick();
        setIdle();
        popCheck(bus.pc);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL timeout: bench did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vecTable[0]  = '{32'd5,         32'd7,         3'b010, 5'd3,  32'd12};
        vecTable[1]  = '{32'd5,         32'd7,         3'b011, 5'd3,  32'hFFFF_FFFE};
        vecTable[2]  = '{32'd5,         32'd7,         3'b010, 5'd0,  32'd12};
        vecTable[3]  = '{32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b000, 5'd4,  32'h00F0_00F0};
        vecTable[4]  = '{32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b001, 5'd5,  32'hFFF0_FFF0};
        vecTable[5]  = '{32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b101, 5'd6,  32'hFF00_FF00};
        vecTable[6]  = '{32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b110, 5'd7,  32'h000F_000F};
        vecTable[7]  = '{32'hFFFF_FFFF, 32'd1,         3'b100, 5'd8,  32'd1};
        vecTable[8]  = '{32'd1,         32'hFFFF_FFFF, 3'b100, 5'd9,  32'd0};
        vecTable[9]  = '{32'h1234_5678, 32'hABCD_EF01, 3'b111, 5'd10, 32'hABCD_EF01};
        vecTable[10] = '{32'hFFFF_FFFF, 32'd1,         3'b010, 5'd11, 32'd0};
        vecTable[11] = '{32'd9,         32'd9,         3'b011, 5'd12, 32'd0};

        for (int i = 0; i < 64; i++) memArr[i] = 32'hFFFF_FFFF;
        setIdle();

        // reset with every state-changing enable held high
        rst                = 1'b1;
        bus.pc_write       = 1'b1;
        bus.pc_write_cond  = 1'b1;
        bus.ir_write       = 1'b1;
        bus.reg_write      = 1'b1;
        bus.mem_to_reg     = 1'b1;
        bus.pc_source      = 2'b00;
        bus.alu_src_b      = 2'b01;
        tick();
        tick();
        rst = 1'b0;
        setIdle();
        #1;
        checkOutput("reset pc", bus.pc, 32'd0);
        checkOutput("reset op", {26'd0, bus.op}, 32'd0);
        checkOutput("reset B", bus.mem_wdata, 32'd0);
        bus.i_or_d = 1'b1;
        #1;
        checkOutput("reset aluout", bus.mem_addr, 32'd0);
        setIdle();
        for (int r = 0; r < 32; r++) readReg("reset rf", r[4:0], 32'd0);

        // fetch from PC 0
        memArr[0]     = 32'h2C22_1800;
        bus.alu_src_a = 1'b0;
        bus.alu_src_b = 2'b01;
        bus.alu_op    = 3'b010;
        bus.pc_source = 2'b00;
        bus.pc_write  = 1'b1;
        bus.ir_write  = 1'b1;
        bus.i_or_d    = 1'b0;
        tick();
        setIdle();
        checkOutput("fetch op", {26'd0, bus.op}, 32'h0000_000B);
        checkOutput("fetch pc", bus.pc, 32'd1);
        bus.i_or_d = 1'b1;
        #1;
        checkOutput("fetch aluout", bus.mem_addr, 32'd1);
        setIdle();

        // table-driven ALU / writeback vectors
        for (int i = 0; i < 12; i++) applyStimulus(vecTable[i]);

        // write and read of the same register in one cycle returns the old value
        writeReg(5'd3, 32'h0000_0011);
        writeReg(5'd1, 32'h0000_0020);
        loadIr({6'h10, 5'd1, 5'd3, 5'd3, 11'd0});
        tick();
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 3'b010;
        tick();
        bus.reg_write = 1'b1;
        pushExp("rf read old", 32'h0000_0011);
        tick();
        setIdle();
        popCheck(bus.mem_wdata);
        pushExp("rf read new", 32'h0000_0031);
        tick();
        popCheck(bus.mem_wdata);

        // branches with r1 == r2
        writeReg(5'd1, 32'd9);
        writeReg(5'd2, 32'd9);
        doBranch(16'hFFFE, 1'b1, 1'b0, 32'd3, 32'd3);
        doBranch(16'hFFFE, 1'b1, 1'b1, 32'd3, 32'd5);
        doBranch(16'h07FF, 1'b0, 1'b0, 32'd4, 32'd4);
        doBranch(16'h07FF, 1'b1, 1'b0, 32'h0000_0804, 32'h0000_0804);

        // store B to address 8
        writeReg(5'd2, 32'hDEAD_BEEF);
        loadIr({6'h2B, 5'd0, 5'd2, 16'd8});
        tick();
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.alu_op    = 3'b010;
        tick();
        setIdle();
        bus.i_or_d    = 1'b1;
        bus.mem_write = 1'b1;
        #1;
        checkOutput("store we", {31'd0, bus.mem_we}, 32'd1);
        checkOutput("store addr", bus.mem_addr, 32'd8);
        checkOutput("store data", bus.mem_wdata, 32'hDEAD_BEEF);
        tick();
        setIdle();
        #1;
        checkOutput("store we drop", {31'd0, bus.mem_we}, 32'd0);
        checkOutput("store memory", memArr[8], 32'hDEAD_BEEF);

        // load address 8 into r5
        loadIr({6'h23, 5'd0, 5'd5, 16'd8});
        tick();
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.alu_op    = 3'b010;
        tick();
        setIdle();
        bus.i_or_d   = 1'b1;
        bus.mem_read = 1'b1;
        #1;
        checkOutput("load re", {31'd0, bus.mem_re}, 32'd1);
        tick();
        setIdle();
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        tick();
        setIdle();
        readReg("load rt", 5'd5, 32'hDEAD_BEEF);

        // move PC to 0x0400_0010 via pass-B, then jump within the region
        writeReg(5'd4, 32'h0400_0010);
        loadIr({6'h23, 5'd0, 5'd4, 16'h0000});
        tick();
        bus.alu_src_b = 2'b00;
        bus.alu_op    = 3'b111;
        bus.pc_source = 2'b00;
        bus.pc_write  = 1'b1;
        pushExp("pc preset", 32'h0400_0010);
        tick();
        setIdle();
        popCheck(bus.pc);
        loadIr({6'h02, 26'h000_0123});
        bus.pc_source = 2'b10;
        bus.pc_write  = 1'b1;
        pushExp("jump pc", 32'h0400_0123);
        tick();
        setIdle();
        popCheck(bus.pc);

        // reset arriving during a jump wins
        loadIr({6'h02, 26'h000_0456});
        bus.pc_source = 2'b10;
        bus.pc_write  = 1'b1;
        rst           = 1'b1;
        tick();
        rst = 1'b0;
        setIdle();
        #1;
        checkOutput("reset mid-jump pc", bus.pc, 32'd0);
        checkOutput("reset mid-jump op", {26'd0, bus.op}, 32'd0);

        if (valQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: %0d expectations never checked", valQ.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
